// File: rtl/register_bank_pkg.sv
// Shared types and address decode for register_bank.
// Named indices give peripheral wiring stable register positions.
package register_bank_pkg;

  typedef enum logic [1:0] {
    RegionRw,
    RegionRo,
    RegionStatus,
    RegionUnmapped
  } region_e;

  // RW register roles used by top-level wiring
  localparam int unsigned RM    = 0;   // RAM address
  localparam int unsigned RLD   = 1;   // LEDs
  localparam int unsigned RTM0  = 2;   // timer reload
  localparam int unsigned RTMS  = 3;   // timer start strobe
  localparam int unsigned RFBX  = 4;   // framebuffer x
  localparam int unsigned RFBY  = 5;   // framebuffer y
  localparam int unsigned RLCD  = 6;   // LCD data
  localparam int unsigned RIRQM = 31;  // interrupt mask

  // STATUS sits directly after the RO region
  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned rw_num,
                                            input int unsigned ro_num);
    if (addr < rw_num) begin
      return RegionRw;
    end else if (addr < rw_num + ro_num) begin
      return RegionRo;
    end else if (addr == rw_num + ro_num) begin
      return RegionStatus;
    end
    return RegionUnmapped;
  endfunction

endpackage

// File: rtl/irq_status_reg.sv
// Sticky interrupt status with write-1-to-clear; a same-cycle event beats the clear.
// Exposes its next state so the bank can forward it to the read ports.
module irq_status_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] event_i,
  input  logic              clr_en_i,
  input  logic [DATA_W-1:0] clr_data_i,
  input  logic [DATA_W-1:0] mask_i,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] status_d_o,
  output logic              pending_o
);

  logic [DATA_W-1:0] status_q, status_d, clr;

  always_comb begin
    clr      = clr_en_i ? clr_data_i : '0;
    status_d = (status_q & ~clr) | event_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o   = status_q;
  assign status_d_o = status_d;
  assign pending_o  = |(status_q & mask_i);

endmodule

// File: rtl/register_bank.sv
// Parametrised CPU register bank: RW array with strobes, RO inputs, IRQ status, wr_err.
// Define REGISTER_BANK_BYPASS_EN to forward same-cycle write data to the read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       ADDR_W       = 6,
  parameter int unsigned       RW_NUM       = 32,
  parameter int unsigned       RO_NUM       = 8,
  parameter logic [RW_NUM-1:0] STROBE_MASK  = '0,
  parameter int unsigned       IRQ_MASK_IDX = 31
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     w_enable_i,
  input  logic [ADDR_W-1:0]        w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic [ADDR_W-1:0]        r_addr_a_i,
  input  logic [ADDR_W-1:0]        r_addr_b_i,
  output logic [DATA_W-1:0]        r_data_a_o,
  output logic [DATA_W-1:0]        r_data_b_o,
  output logic [RW_NUM*DATA_W-1:0] rw_regs_o,
  input  logic [RO_NUM*DATA_W-1:0] ro_regs_i,
  input  logic [DATA_W-1:0]        irq_event_i,
  output logic [DATA_W-1:0]        irq_status_o,
  output logic                     irq_pending_o,
  output logic                     wr_err_o
);

  localparam int unsigned StatusAddr = RW_NUM + RO_NUM;
`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  if (RW_NUM + RO_NUM + 1 > (1 << ADDR_W)) begin : g_err_addr_space
    $error("register_bank: address map does not fit in ADDR_W bits");
  end
  if (IRQ_MASK_IDX >= RW_NUM) begin : g_err_mask_idx
    $error("register_bank: IRQ_MASK_IDX outside the RW region");
  end

  logic [DATA_W-1:0] rw_q [RW_NUM];
  logic [DATA_W-1:0] rw_d [RW_NUM];
  logic [DATA_W-1:0] status_q, status_d;
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_data [2];
  region_e           w_region;
  logic              status_wr, wr_err_d, wr_err_q;

  assign w_region  = decode_region(32'(w_addr_i), RW_NUM, RO_NUM);
  assign status_wr = w_enable_i && (w_region == RegionStatus);
  assign wr_err_d  = w_enable_i && ((w_region == RegionRo) || (w_region == RegionUnmapped));

  // Strobe registers fall back to zero unless rewritten on this edge
  always_comb begin
    for (int unsigned i = 0; i < RW_NUM; i++) begin
      rw_d[i] = STROBE_MASK[i] ? '0 : rw_q[i];
      if (w_enable_i && (w_addr_i == ADDR_W'(i))) begin
        rw_d[i] = w_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RW_NUM; i++) begin
        rw_q[i] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      rw_q     <= rw_d;
      wr_err_q <= wr_err_d;
    end
  end

  irq_status_reg #(
    .DATA_W(DATA_W)
  ) u_irq_status_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .event_i    (irq_event_i),
    .clr_en_i   (status_wr),
    .clr_data_i (w_data_i),
    .mask_i     (rw_q[IRQ_MASK_IDX]),
    .status_o   (status_q),
    .status_d_o (status_d),
    .pending_o  (irq_pending_o)
  );

  assign r_addr[0] = r_addr_a_i;
  assign r_addr[1] = r_addr_b_i;

  // Unmatched addresses fall through to zero
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      r_data[p] = '0;
      for (int unsigned i = 0; i < RW_NUM; i++) begin
        if (r_addr[p] == ADDR_W'(i)) begin
          r_data[p] = (BypassEn && w_enable_i && (w_addr_i == r_addr[p])) ? w_data_i : rw_q[i];
        end
      end
      for (int unsigned j = 0; j < RO_NUM; j++) begin
        if (r_addr[p] == ADDR_W'(RW_NUM + j)) begin
          r_data[p] = ro_regs_i[j*DATA_W +: DATA_W];
        end
      end
      if (r_addr[p] == ADDR_W'(StatusAddr)) begin
        r_data[p] = (BypassEn && status_wr) ? status_d : status_q;
      end
    end
  end

  assign r_data_a_o = r_data[0];
  assign r_data_b_o = r_data[1];

  always_comb begin
    for (int unsigned i = 0; i < RW_NUM; i++) begin
      rw_regs_o[i*DATA_W +: DATA_W] = rw_q[i];
    end
  end

  assign irq_status_o = status_q;
  assign wr_err_o     = wr_err_q;

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised successor to the fixed 8-bit CPU register file. It provides a configurable bank of read/write registers and read-only peripheral inputs, with two combinational read ports and one synchronous write port. It adds self-clearing strobe registers, a sticky write-1-to-clear interrupt status register with a mask and a pending output, and a registered error pulse for illegal writes. It sits between the CPU datapath and the peripheral wiring (RAM address, random, LEDs, timer, framebuffer, LCD).

## Interface
- DATA_W, 8: register width in bits
- ADDR_W, 6: register address width
- RW_NUM, 32: number of read/write registers, at addresses 0..RW_NUM-1
- RO_NUM, 8: number of read-only inputs, at addresses RW_NUM..RW_NUM+RO_NUM-1
- STROBE_MASK, 0 (RW_NUM bits): bit i set means RW register i self-clears
- IRQ_MASK_IDX, 31: index of the RW register used as the interrupt mask
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- w_enable  in  1  write request
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- r_addr_a, r_addr_b  in  ADDR_W  read addresses
- r_data_a, r_data_b  out  DATA_W  read data, combinational
- rw_regs  out  RW_NUM*DATA_W  flattened RW contents; register i occupies [i*DATA_W+:DATA_W]
- ro_regs  in  RO_NUM*DATA_W  flattened peripheral read-only values
- irq_event  in  DATA_W  per-bit event pulses that set status bits
- irq_status  out  DATA_W  sticky status register
- irq_pending  out  1  |(irq_status & mask register)
- wr_err  out  1  one-cycle pulse after an illegal write

## Operation
- Address map:
  - RW region: 0..RW_NUM-1
  - RO region: RW_NUM..RW_NUM+RO_NUM-1
  - STATUS: RW_NUM+RO_NUM
  - Every other address is unmapped.
- Elaboration error if RW_NUM+RO_NUM+1 > 2**ADDR_W, or if IRQ_MASK_IDX >= RW_NUM.
- RW write: the register takes w_data on the edge.
- Strobe registers (STROBE_MASK bit set):
  - A written value is visible for exactly one cycle, then the register returns to 0.
  - If writes occur on back-to-back cycles, each write value is held for one cycle.
- RO region:
  - Reads return the live ro_regs slice.
  - Writes are ignored and raise wr_err.
- STATUS:
  - Bit i sets when irq_event[i]=1 at the edge.
  - A write clears every bit where w_data=1.
  - If set and clear hit the same bit in the same cycle, set wins.
- Unmapped addresses: reads return 0; writes are ignored and raise wr_err.
- irq_pending is combinational from irq_status and the mask register.

## Timing
- Reset (rst=0, asynchronous) forces all RW registers, irq_status and wr_err to 0, so irq_pending=0.
- Releasing reset takes effect on the first edge after deassertion.
- Write latency is one cycle: the new value appears on rw_regs, and on the read ports, after the edge.
- Read latency is zero (combinational). The default read-during-write behaviour is old data (see Configuration).
- wr_err goes high in the cycle after the illegal write and stays high for exactly one cycle.
- A strobe register reads the written value for one cycle after the write edge and 0 afterwards.
- An irq_event bit pulsed for one cycle sets its status bit at that edge; irq_pending rises in the same cycle if the bit is unmasked.
- Reset asserted mid-strobe or mid-event clears everything immediately. Events occurring while reset is asserted are lost.

## Configuration
- REGISTER_BANK_BYPASS_EN:
  - Defined: a read from an address that is being written in the same cycle returns the next-state value. For RW this is w_data. For STATUS it is the post-clear, post-set value.
  - Undefined: reads return the current registered value.
  - RO and unmapped reads are identical in both builds.

## Structure
- Package register_bank_pkg holds:
  - the address-region decode function (returns RW / RO / STATUS / UNMAPPED)
  - the region enum
  - the named register index constants (RM, RLD, RTM0, RTMS, RFBX, ...) used by top-level wiring
- Sub-module irq_status_reg (DATA_W param) owns:
  - the sticky set / W1C logic
  - the mask AND
  - irq_pending
- register_bank owns the RW array, strobe clearing, read muxes, bypass and wr_err.

## Test plan
- Reset, then write 0xA5 to address 3 → r_data_a(3)=0xA5 the next cycle; rw_regs[31:24]=0xA5; wr_err stays 0.
- With STROBE_MASK bit 5 set, write 0x01 to address 5 → reads 0x01 for exactly one cycle, then 0x00.
- Drive ro_regs slice 2 = 0x3C → reading RW_NUM+2 gives 0x3C; writing 0xFF there leaves it unchanged and pulses wr_err for one cycle. Writing address 63 gives the same response.
- Set mask=0x04, pulse irq_event=0x06 → irq_status=0x06 and irq_pending=1. Write 0x04 to STATUS → irq_status=0x02, irq_pending=0.
- Pulse irq_event=0x01 while writing 0x01 to STATUS in the same cycle → irq_status bit 0 remains 1.
- With REGISTER_BANK_BYPASS_EN defined, write 0x77 to address 4 while r_addr_b=4 → r_data_b=0x77 in the same cycle. Undefined build → r_data_b shows the old value.
